// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: sequential packed-BCD to binary converter, one digit per clock,
// most-significant digit first (acc = acc*10 + digit).
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-low reset
//   bcd    in   packed BCD word, digit i at [4i+3:4i], sampled when start is accepted
//   start  in   conversion request, accepted while busy==0
//   busy   out  high while a conversion is in progress
//   bin    out  binary result, held until the next completion
//   valid  out  one-cycle pulse when bin/ovf/err update
//   ovf    out  true value exceeded 2**BIN_WIDTH-1 (bin holds the low bits)
//   err    out  a digit was above 9 (bin forced to 0)
module bcd2bin_seq #(
    parameter int BIN_WIDTH  = 8,
    parameter int BCD_DIGITS = $rtoi($ceil($log10(real'(2**BIN_WIDTH-1)))),
    parameter int BCD_WIDTH  = BCD_DIGITS*4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BCD_WIDTH-1:0] bcd,
    input  logic                 start,
    output logic                 busy,
    output logic [BIN_WIDTH-1:0] bin,
    output logic                 valid,
    output logic                 ovf,
    output logic                 err
);

    // Accumulator must hold 10**D-1 and the worst intermediate acc*10 + 15.
    localparam int unsigned ACC_W = (BCD_WIDTH > BIN_WIDTH + 4) ? BCD_WIDTH : BIN_WIDTH + 4;
    localparam int unsigned CNT_W = (BCD_DIGITS > 1) ? $clog2(BCD_DIGITS) : 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_CONV = 1'b1
    } state_t;

    state_t               r_state;
    logic [BCD_WIDTH-1:0] r_shift;
    logic [ACC_W-1:0]     r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_err_int;
    logic                 r_busy;
    logic                 r_valid;
    logic [BIN_WIDTH-1:0] r_bin;
    logic                 r_ovf;
    logic                 r_err;

    logic [3:0]           w_digit;
    logic [ACC_W-1:0]     w_acc_next;
    logic                 w_err_next;
    logic                 w_ovf;

    // Datapath for the digit currently at the top of the shift register.
    assign w_digit    = r_shift[BCD_WIDTH-1 -: 4];
    assign w_acc_next = (r_acc << 3) + (r_acc << 1) + ACC_W'(w_digit);
    assign w_err_next = r_err_int | (w_digit > 4'd9);
    assign w_ovf      = |w_acc_next[ACC_W-1:BIN_WIDTH];

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_err_int <= 1'b0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_bin     <= '0;
            r_ovf     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_shift   <= bcd;
                        r_acc     <= '0;
                        r_cnt     <= CNT_W'(BCD_DIGITS - 1);
                        r_err_int <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= S_CONV;
                    end
                end
                S_CONV: begin
                    r_acc     <= w_acc_next;
                    r_shift   <= r_shift << 4;
                    r_err_int <= w_err_next;
                    r_cnt     <= r_cnt - CNT_W'(1);
                    if (r_cnt == '0) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_valid <= 1'b1;
                        r_err   <= w_err_next;
                        if (w_err_next) begin
                            r_bin <= '0;
                            r_ovf <= 1'b0;
                        end else begin
                            r_bin <= w_acc_next[BIN_WIDTH-1:0];
                            r_ovf <= w_ovf;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy  = r_busy;
    assign valid = r_valid;
    assign bin   = r_bin;
    assign ovf   = r_ovf;
    assign err   = r_err;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// tb_bcd2bin_seq: directed-vector bench for bcd2bin_seq, default 8-bit
// instance plus a 10-bit (4-digit) instance.
module tb_bcd2bin_seq;

    logic        clk = 1'b0;
    logic        rst;

    logic [11:0] bcd;
    logic        start;
    logic        busy;
    logic [7:0]  bin;
    logic        valid;
    logic        ovf;
    logic        err;

    logic [15:0] bcd_w;
    logic        start_w;
    logic        busy_w;
    logic [9:0]  bin_w;
    logic        valid_w;
    logic        ovf_w;
    logic        err_w;

    int n_checks = 0;
    int n_fail   = 0;

    bcd2bin_seq dut (
        .clk   (clk),
        .rst   (rst),
        .bcd   (bcd),
        .start (start),
        .busy  (busy),
        .bin   (bin),
        .valid (valid),
        .ovf   (ovf),
        .err   (err)
    );

    bcd2bin_seq #(.BIN_WIDTH(10)) dut_w (
        .clk   (clk),
        .rst   (rst),
        .bcd   (bcd_w),
        .start (start_w),
        .busy  (busy_w),
        .bin   (bin_w),
        .valid (valid_w),
        .ovf   (ovf_w),
        .err   (err_w)
    );

    always #5 clk = ~clk;

    // Drive a one-cycle start; returns at the negedge after the accepting edge.
    task automatic pulse_start(input logic wide, input logic [15:0] value);
        @(negedge clk);
        if (wide) begin bcd_w = value; start_w = 1'b1; end
        else begin bcd = value[11:0]; start = 1'b1; end
        @(negedge clk);
        start   = 1'b0;
        start_w = 1'b0;
    endtask

    // Count negedges until valid is seen; -1 if it never comes.
    task automatic wait_valid(input logic wide, output int n);
        n = -1;
        for (int i = 0; i < 20; i++) begin
            if ((wide ? valid_w : valid) === 1'b1) begin
                n = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start_w = 1'b0; bcd = '0; bcd_w = '0;
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if ({busy, valid, ovf, err} !== 4'b0000 || bin !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b valid=%b ovf=%b err=%b bin=%0d, want all 0",
                     busy, valid, ovf, err, bin);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int n;
        pulse_start(1'b0, 16'h0255);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (busy !== 1'b1 || valid !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_busy[%0d]: got busy=%b valid=%b, want busy=1 valid=0", i, busy, valid);
            end
            @(negedge clk);
        end
        n_checks++;
        if (valid !== 1'b1 || busy !== 1'b0 || bin !== 8'd255 || ovf !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_255: got valid=%b busy=%b bin=%0d ovf=%b err=%b, want 1 0 255 0 0",
                     valid, busy, bin, ovf, err);
        end
        @(negedge clk);
        n_checks++;
        if (valid !== 1'b0 || bin !== 8'd255) begin
            n_fail++;
            $display("FAIL basic_pulse_len: got valid=%b bin=%0d, want valid=0 bin=255", valid, bin);
        end
        n = 0;
    endtask

    task automatic test_overflow();
        int n;
        pulse_start(1'b0, 16'h0256);
        wait_valid(1'b0, n);
        n_checks++;
        if (n !== 3 || bin !== 8'd0 || ovf !== 1'b1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_256: got lat=%0d bin=%0d ovf=%b err=%b, want 3 0 1 0", n, bin, ovf, err);
        end
        pulse_start(1'b0, 16'h0999);
        wait_valid(1'b0, n);
        n_checks++;
        if (n !== 3 || bin !== 8'd231 || ovf !== 1'b1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_999: got lat=%0d bin=%0d ovf=%b err=%b, want 3 231 1 0", n, bin, ovf, err);
        end
    endtask

    task automatic test_error();
        int n;
        pulse_start(1'b0, 16'h01A3);
        wait_valid(1'b0, n);
        n_checks++;
        if (n !== 3 || bin !== 8'd0 || ovf !== 1'b0 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_1A3: got lat=%0d bin=%0d ovf=%b err=%b, want 3 0 0 1", n, bin, ovf, err);
        end
        pulse_start(1'b0, 16'h0042);
        wait_valid(1'b0, n);
        n_checks++;
        if (n !== 3 || bin !== 8'd42 || ovf !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear_042: got lat=%0d bin=%0d ovf=%b err=%b, want 3 42 0 0", n, bin, ovf, err);
        end
    endtask

    task automatic test_start_while_busy();
        int n;
        int pulses;
        pulse_start(1'b0, 16'h0100);
        @(negedge clk);
        bcd = 12'h007; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid(1'b0, n);
        n_checks++;
        if (n !== 1 || bin !== 8'd100) begin
            n_fail++;
            $display("FAIL busy_start_100: got lat=%0d bin=%0d, want 1 100", n, bin);
        end
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (valid === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses !== 0 || bin !== 8'd100) begin
            n_fail++;
            $display("FAIL busy_start_ignored: got extra_valid=%0d bin=%0d, want 0 100", pulses, bin);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        pulse_start(1'b0, 16'h0010);
        wait_valid(1'b0, n);
        n_checks++;
        if (n !== 3 || bin !== 8'd10) begin
            n_fail++;
            $display("FAIL b2b_first: got lat=%0d bin=%0d, want 3 10", n, bin);
        end
        bcd = 12'h020; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_accept: got busy=%b valid=%b, want 1 0", busy, valid);
        end
        wait_valid(1'b0, n);
        n_checks++;
        if (n + 1 !== 4 || bin !== 8'd20) begin
            n_fail++;
            $display("FAIL b2b_second: got spacing=%0d bin=%0d, want 4 20", n + 1, bin);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        pulse_start(1'b0, 16'h0123);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || bin !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got busy=%b valid=%b bin=%0d, want 0 0 0", busy, valid, bin);
        end
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (valid === 1'b1 || busy === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses !== 0 || bin !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_mid_no_valid: got active_cycles=%0d bin=%0d, want 0 0", pulses, bin);
        end
    endtask

    task automatic test_wide();
        int n;
        pulse_start(1'b1, 16'h1023);
        wait_valid(1'b1, n);
        n_checks++;
        if (n !== 4 || bin_w !== 10'd1023 || ovf_w !== 1'b0 || err_w !== 1'b0) begin
            n_fail++;
            $display("FAIL wide_1023: got lat=%0d bin=%0d ovf=%b err=%b, want 4 1023 0 0", n, bin_w, ovf_w, err_w);
        end
        pulse_start(1'b1, 16'h1024);
        wait_valid(1'b1, n);
        n_checks++;
        if (n !== 4 || bin_w !== 10'd0 || ovf_w !== 1'b1 || err_w !== 1'b0) begin
            n_fail++;
            $display("FAIL wide_1024: got lat=%0d bin=%0d ovf=%b err=%b, want 4 0 1 0", n, bin_w, ovf_w, err_w);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_error();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        test_wide();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
